// File: rtl/cmt_dout_fifo.sv
// cmt_dout_fifo: Avalon-MM CMT output port with byte FIFO, valid/ready drain and legacy direct mode
module cmt_dout_fifo #(
  parameter int DATA_W = 8,
  parameter int AW = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_port,
  output logic              irq
);
  localparam int DEPTH = 2**AW;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW:0] wptr_q, wptr_d, rptr_q, rptr_d, level;
  logic [DATA_W-1:0] out_port_q, out_port_d;
  logic enable_q, enable_d, mode_q, mode_d, irq_en_q, irq_en_d, ovf_q, ovf_d;
  logic wr, wr_data, wr_stat, wr_ctrl, flush, empty, full, push, pop;
  logic unused_wdata;
  assign unused_wdata = ^writedata;
  assign out_data = mem_q[rptr_q[AW-1:0]];
  assign out_port = out_port_q;
  // Decode bus writes, FIFO status, handshake and next-state for all registers
  always_comb begin
    wr = chipselect && !write_n;
    wr_data = wr && address == 2'd0;
    wr_stat = wr && address == 2'd1;
    wr_ctrl = wr && address == 2'd2;
    flush = wr_ctrl && writedata[3];
    level = wptr_q - rptr_q;
    empty = wptr_q == rptr_q;
    full = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    out_valid = enable_q && !mode_q && !empty;
    pop = out_valid && out_ready;
    push = wr_data && !mode_q && !full && !flush;
    wptr_d = flush ? '0 : wptr_q + {{AW{1'b0}}, push};
    rptr_d = flush ? '0 : rptr_q + {{AW{1'b0}}, pop};
    out_port_d = pop ? out_data : (wr_data && mode_q) ? writedata[DATA_W-1:0] : out_port_q;
    enable_d = wr_ctrl ? writedata[0] : enable_q;
    mode_d = wr_ctrl ? writedata[1] : mode_q;
    irq_en_d = wr_ctrl ? writedata[2] : irq_en_q;
    ovf_d = (wr_data && !mode_q && full) ? 1'b1 : (wr_stat && writedata[18]) ? 1'b0 : ovf_q;
    irq = irq_en_q && empty && enable_q;
    readdata = address == 2'd0 ? 32'(out_port_q) :
               address == 2'd1 ? (32'(level) | {13'b0, ovf_q, full, empty, 16'b0}) :
               address == 2'd2 ? {29'b0, irq_en_q, mode_q, enable_q} : 32'b0;
  end
  // Control, pointer and output-hold registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      out_port_q <= '0;
      enable_q <= 1'b0;
      mode_q <= 1'b0;
      irq_en_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      out_port_q <= out_port_d;
      enable_q <= enable_d;
      mode_q <= mode_d;
      irq_en_q <= irq_en_d;
      ovf_q <= ovf_d;
    end
  end
  // FIFO storage, cleared on reset so out_data reads 0 while the FIFO is empty after reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wptr_q[AW-1:0]] <= writedata[DATA_W-1:0];
    end
  end
endmodule

// File: tb/tb_cmt_dout_fifo.sv
// tb_cmt_dout_fifo: scoreboard bench for the CMT output FIFO port
module tb_cmt_dout_fifo;
  logic clk = 0;
  logic reset_n = 0;
  logic [1:0] address = 0;
  logic chipselect = 0;
  logic write_n = 1;
  logic [31:0] writedata = 0;
  logic [31:0] readdata;
  logic [7:0] out_data;
  logic out_valid;
  logic out_ready = 0;
  logic [7:0] out_port;
  logic irq;
  int checks = 0;
  int errors = 0;
  logic [7:0] sb[$];
  logic [7:0] m_port = 0;
  logic m_mode = 0;

  cmt_dout_fifo #(.DATA_W(8), .AW(4)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_port(out_port), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
    logic acc;
    acc = (a == 2'd0) && !m_mode && (sb.size() < 16);
    address = a; writedata = d; chipselect = 1; write_n = 0;
    @(posedge clk); #1;
    chipselect = 0; write_n = 1; address = 0;
    if (acc) sb.push_back(d[7:0]);
    if (a == 2'd0 && m_mode) m_port = d[7:0];
    if (a == 2'd2) begin
      m_mode = d[1];
      if (d[3]) sb.delete();
    end
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    address = a; #1;
    v = readdata;
    address = 0;
  endtask

  task automatic test_reset;
    logic [31:0] v;
    repeat (2) @(posedge clk);
    #1 reset_n = 1;
    rd(2'd1, v);
    checks++; if (v !== 32'h0001_0000) begin errors++; $display("FAIL reset_status got=%h exp=%h", v, 32'h0001_0000); end
    checks++; if (out_port !== 8'h00) begin errors++; $display("FAIL reset_out_port got=%h exp=00", out_port); end
    checks++; if (out_valid !== 1'b0 || irq !== 1'b0) begin errors++; $display("FAIL reset_valid_irq got=%b%b exp=00", out_valid, irq); end
  endtask

  task automatic test_legacy;
    logic [31:0] v;
    bus_wr(2'd2, 32'h02);
    bus_wr(2'd0, 32'hFFFF_FFA5);
    checks++; if (out_port !== 8'hA5) begin errors++; $display("FAIL legacy_out_port got=%h exp=a5", out_port); end
    rd(2'd0, v);
    checks++; if (v !== 32'h0000_00A5) begin errors++; $display("FAIL legacy_readback got=%h exp=000000a5", v); end
    rd(2'd1, v);
    checks++; if (v !== 32'h0001_0000 || out_valid !== 1'b0) begin errors++; $display("FAIL legacy_fifo_untouched status=%h valid=%b exp=00010000/0", v, out_valid); end
    bus_wr(2'd2, 32'h00);
  endtask

  task automatic test_fifo_order;
    logic [31:0] v;
    logic [7:0] exp [3];
    exp[0] = 8'h11; exp[1] = 8'h22; exp[2] = 8'h33;
    bus_wr(2'd2, 32'h05);
    for (int i = 0; i < 3; i++) bus_wr(2'd0, {24'h0, exp[i]});
    checks++; if (out_valid !== 1'b1 || out_data !== 8'h11) begin errors++; $display("FAIL order_head valid=%b data=%h exp=1/11", out_valid, out_data); end
    rd(2'd1, v);
    checks++; if (v !== 32'h3) begin errors++; $display("FAIL order_level got=%h exp=3", v); end
    out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++; if (out_port !== exp[i]) begin errors++; $display("FAIL order_out_port[%0d] got=%h exp=%h", i, out_port, exp[i]); end
    end
    out_ready = 0;
    rd(2'd1, v);
    checks++; if (v !== 32'h0001_0000 || irq !== 1'b1) begin errors++; $display("FAIL order_empty_irq status=%h irq=%b exp=00010000/1", v, irq); end
  endtask

  task automatic test_mode_switch;
    logic [31:0] v;
    bus_wr(2'd0, 32'h44);
    bus_wr(2'd2, 32'h03);
    rd(2'd1, v);
    checks++; if (out_valid !== 1'b0 || v !== 32'h1) begin errors++; $display("FAIL mode_hold valid=%b status=%h exp=0/1", out_valid, v); end
    bus_wr(2'd2, 32'h01);
    checks++; if (out_valid !== 1'b1 || out_data !== 8'h44) begin errors++; $display("FAIL mode_resume valid=%b data=%h exp=1/44", out_valid, out_data); end
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    checks++; if (out_port !== 8'h44) begin errors++; $display("FAIL mode_drain got=%h exp=44", out_port); end
  endtask

  task automatic test_full_overflow;
    logic [31:0] v;
    int n;
    bus_wr(2'd2, 32'h00);
    for (int i = 0; i <= 16; i++) bus_wr(2'd0, i);
    rd(2'd1, v);
    checks++; if (v !== 32'h0006_0010) begin errors++; $display("FAIL full_status got=%h exp=00060010", v); end
    bus_wr(2'd1, 32'h0004_0000);
    rd(2'd1, v);
    checks++; if (v !== 32'h0002_0010) begin errors++; $display("FAIL ovf_clear got=%h exp=00020010", v); end
    bus_wr(2'd2, 32'h01);
    out_ready = 1;
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (sb.size() == 0) begin @(posedge clk); #1; end
    out_ready = 0;
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL full_drain_timeout left=%0d exp=0", sb.size()); end
    rd(2'd1, v);
    checks++; if (v !== 32'h0001_0000 || out_port !== 8'h0F) begin errors++; $display("FAIL full_drain_end status=%h port=%h exp=00010000/0f", v, out_port); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] v;
    for (int i = 0; i < 5; i++) bus_wr(2'd0, 32'h50 + i);
    out_ready = 1;
    for (int i = 0; i < 40; i++) begin
      bus_wr(2'd0, 32'h60 + i);
      rd(2'd1, v);
      checks++; if (v !== 32'h5) begin errors++; $display("FAIL b2b_level[%0d] got=%h exp=5", i, v); end
    end
    out_ready = 0;
    for (int i = 0; i < 11; i++) bus_wr(2'd0, 32'hA0 + i);
    rd(2'd1, v);
    checks++; if (v !== 32'h0002_0010) begin errors++; $display("FAIL b2b_full got=%h exp=00020010", v); end
    out_ready = 1;
    bus_wr(2'd0, 32'hEE);
    out_ready = 0;
    rd(2'd1, v);
    checks++; if (v !== 32'h0004_000F) begin errors++; $display("FAIL b2b_full_push_pop got=%h exp=0004000f", v); end
    bus_wr(2'd1, 32'h0004_0000);
  endtask

  task automatic test_flush;
    logic [31:0] v;
    bus_wr(2'd2, 32'h08);
    for (int i = 0; i < 8; i++) bus_wr(2'd0, 32'h80 + i);
    rd(2'd1, v);
    checks++; if (v !== 32'h8) begin errors++; $display("FAIL flush_prefill got=%h exp=8", v); end
    bus_wr(2'd2, 32'h08);
    rd(2'd1, v);
    checks++; if (v !== 32'h0001_0000 || out_valid !== 1'b0 || out_port !== m_port) begin errors++; $display("FAIL flush_idle status=%h valid=%b port=%h exp=00010000/0/%h", v, out_valid, out_port, m_port); end
    bus_wr(2'd2, 32'h01);
    for (int i = 1; i <= 3; i++) bus_wr(2'd0, 32'hC0 + i);
    out_ready = 1;
    bus_wr(2'd2, 32'h09);
    out_ready = 0;
    rd(2'd1, v);
    checks++; if (v !== 32'h0001_0000 || out_valid !== 1'b0 || out_port !== 8'hC1) begin errors++; $display("FAIL flush_with_transfer status=%h valid=%b port=%h exp=00010000/0/c1", v, out_valid, out_port); end
  endtask

  task automatic test_async_reset;
    logic [31:0] v;
    bus_wr(2'd2, 32'h05);
    for (int i = 0; i < 3; i++) bus_wr(2'd0, 32'hD0 + i);
    out_ready = 1;
    #2 reset_n = 0;
    #1;
    checks++; if (out_valid !== 1'b0 || out_data !== 8'h00 || out_port !== 8'h00 || irq !== 1'b0 || readdata !== 32'h0) begin
      errors++; $display("FAIL async_reset valid=%b data=%h port=%h irq=%b rd=%h exp=all 0", out_valid, out_data, out_port, irq, readdata);
    end
    sb.delete(); m_port = 0; m_mode = 0;
    out_ready = 0;
    @(posedge clk); #1 reset_n = 1;
    rd(2'd1, v);
    checks++; if (v !== 32'h0001_0000 || out_valid !== 1'b0) begin errors++; $display("FAIL async_reset_release status=%h valid=%b exp=00010000/0", v, out_valid); end
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        if (reset_n && out_valid && out_ready) begin
          checks++;
          if (sb.size() == 0) begin
            errors++; $display("FAIL transfer_unexpected data=%h exp=no transfer", out_data);
          end else begin
            if (out_data !== sb[0]) begin errors++; $display("FAIL transfer_data got=%h exp=%h", out_data, sb[0]); end
            m_port = sb.pop_front();
          end
        end
      end
    join_none
    test_reset();
    test_legacy();
    test_fifo_order();
    test_mode_switch();
    test_full_overflow();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
